// File: rtl/spi_pkg.sv
// Shared types and constants for the system-clocked SPI slave.
package spi_pkg;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned MIN_CLK_RATIO = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

    typedef struct packed {
        logic sample_rise;
        logic shift_rise;
    } edge_roles_t;

    // Leading edge is a rise when CPOL=0; CPHA picks whether we sample on it or shift on it.
    function automatic edge_roles_t decode_roles(input bit cpol, input bit cpha);
        edge_roles_t r;
        r.sample_rise = (cpol == cpha);
        r.shift_rise  = (cpol != cpha);
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Word-level handshake between the SPI slave and the register/stream logic.
interface spi_slave_sync_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] slave_tx_data;
    logic              slave_tx_valid;
    logic              slave_tx_ack;
    logic [DATA_W-1:0] slave_rx_data;
    logic              slave_rx_valid;
    logic              slave_underrun;
    logic              slave_frame_err;

    modport slave (
        input  slave_tx_data, slave_tx_valid,
        output slave_tx_ack, slave_rx_data, slave_rx_valid, slave_underrun, slave_frame_err
    );

    modport master (
        output slave_tx_data, slave_tx_valid,
        input  slave_tx_ack, slave_rx_data, slave_rx_valid, slave_underrun, slave_frame_err
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser for an asynchronous pin with rise/fall pulses from one extra flop.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk_i,
    input  logic d_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // No reset: the chain always tracks the live pin, so a reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
        last_q <= sync_q[STAGES-1];
    end

    assign rise_c_o =  sync_q[STAGES-1] & ~last_q;
    assign fall_c_o = ~sync_q[STAGES-1] &  last_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on slave_clk; SCK/SS/MOSI are oversampled pins.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter bit                CPOL       = 1'b0,
    parameter bit                CPHA       = 1'b0,
    parameter bit                MSB_FIRST  = 1'b1,
    parameter logic [DATA_W-1:0] DEFAULT_TX = '1
) (
    input  logic              slave_clk,
    input  logic              slave_reset,
    input  logic              slave_sck,
    input  logic              slave_ss,
    input  logic              slave_mosi,
    output logic              slave_miso,
    output logic              slave_miso_oe,
    spi_slave_sync_if.slave   bus
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam int unsigned       OUT_IDX  = MSB_FIRST ? DATA_W - 1 : 0;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam edge_roles_t       ROLES    = decode_roles(CPOL, CPHA);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i    (slave_clk),
        .d_i      (slave_sck),
        .rise_c_o (sck_rise),
        .fall_c_o (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk_i    (slave_clk),
        .d_i      (slave_ss),
        .rise_c_o (ss_rise),
        .fall_c_o (ss_fall)
    );

    always_ff @(posedge slave_clk) begin
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], slave_mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic sample_ev, shift_ev;
    assign sample_ev = ROLES.sample_rise ? sck_rise : sck_fall;
    assign shift_ev  = ROLES.shift_rise  ? sck_rise : sck_fall;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ack_q, tx_ack_d;
    logic              underrun_q, underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_oe_q, miso_oe_d;
    logic              skip_q, skip_d;

    logic [DATA_W-1:0] rx_next, tx_adv, tx_fill;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_ack_d    = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_oe_d   = miso_oe_q;
        skip_d      = skip_q;

        rx_next = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift_q[DATA_W-1:1]};
        tx_adv  = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}   : {1'b0, tx_shift_q[DATA_W-1:1]};
        tx_fill = bus.slave_tx_valid ? bus.slave_tx_data : DEFAULT_TX;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_shift_d = tx_fill;
                tx_ack_d   = bus.slave_tx_valid;
                underrun_d = ~bus.slave_tx_valid;
                bit_cnt_d  = '0;
                miso_oe_d  = 1'b1;
                skip_d     = CPHA;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sample_ev) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Word done: publish it and present the next word's first bit immediately.
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = tx_fill;
                        tx_ack_d   = bus.slave_tx_valid;
                        underrun_d = ~bus.slave_tx_valid;
                        skip_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_ev) begin
                    // The shift right after a (re)load would discard the bit just presented.
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_adv;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deselect wins over everything; a word completing in the same cycle still counts.
        if (ss_rise) begin
            frame_err_d = (state_q == SHIFT) && (bit_cnt_d != '0);
            state_d     = IDLE;
            miso_oe_d   = 1'b0;
            tx_shift_d  = '0;
            bit_cnt_d   = '0;
            skip_d      = 1'b0;
            tx_ack_d    = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    always_ff @(posedge slave_clk) begin
        if (slave_reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ack_q    <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_oe_q   <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ack_q    <= tx_ack_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            miso_oe_q   <= miso_oe_d;
            skip_q      <= skip_d;
        end
    end

    // tx_shift is cleared whenever the slave is deselected, so miso idles low.
    assign slave_miso          = tx_shift_q[OUT_IDX];
    assign slave_miso_oe       = miso_oe_q;
    assign bus.slave_tx_ack    = tx_ack_q;
    assign bus.slave_rx_data   = rx_data_q;
    assign bus.slave_rx_valid  = rx_valid_q;
    assign bus.slave_underrun  = underrun_q;
    assign bus.slave_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: four slave variants share SCK/MOSI, each with its own SS and handshake.
module tb_spi_slave_sync;
    import spi_pkg::*;

    localparam int unsigned CLK_P = 10;
    localparam int unsigned H     = MIN_CLK_RATIO * CLK_P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic [3:0] ss_n = 4'hF;
    logic       miso0, miso1, miso2, miso3;
    logic       oe0, oe1, oe2, oe3;
    logic       miso_m;
    int         sel = 0;
    int         checks = 0;
    int         failures = 0;
    int         ack_c[4], rxv_c[4], und_c[4], err_c[4];
    logic [15:0] q0[$], q1[$], q2[$], q3[$];

    always #(CLK_P / 2) clk = ~clk;

    spi_slave_sync_if #(.DATA_W(8))  if0 ();
    spi_slave_sync_if #(.DATA_W(8))  if1 ();
    spi_slave_sync_if #(.DATA_W(16)) if2 ();
    spi_slave_sync_if #(.DATA_W(8))  if3 ();

    spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
        .slave_clk(clk), .slave_reset(rst), .slave_sck(sck), .slave_ss(ss_n[0]),
        .slave_mosi(mosi), .slave_miso(miso0), .slave_miso_oe(oe0), .bus(if0));
    spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
        .slave_clk(clk), .slave_reset(rst), .slave_sck(sck), .slave_ss(ss_n[1]),
        .slave_mosi(mosi), .slave_miso(miso1), .slave_miso_oe(oe1), .bus(if1));
    spi_slave_sync #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0)) u2 (
        .slave_clk(clk), .slave_reset(rst), .slave_sck(sck), .slave_ss(ss_n[2]),
        .slave_mosi(mosi), .slave_miso(miso2), .slave_miso_oe(oe2), .bus(if2));
    spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u3 (
        .slave_clk(clk), .slave_reset(rst), .slave_sck(sck), .slave_ss(ss_n[3]),
        .slave_mosi(mosi), .slave_miso(miso3), .slave_miso_oe(oe3), .bus(if3));

    always_comb begin
        case (sel)
            0:       miso_m = miso0;
            1:       miso_m = miso1;
            2:       miso_m = miso2;
            default: miso_m = miso3;
        endcase
    end

    // Pulse counters plus a producer that pops its word queue on every tx_ack.
    always @(posedge clk) begin
        #1;
        if (if0.slave_tx_ack) ack_c[0]++;
        if (if1.slave_tx_ack) ack_c[1]++;
        if (if2.slave_tx_ack) ack_c[2]++;
        if (if3.slave_tx_ack) ack_c[3]++;
        if (if0.slave_rx_valid) rxv_c[0]++;
        if (if1.slave_rx_valid) rxv_c[1]++;
        if (if2.slave_rx_valid) rxv_c[2]++;
        if (if3.slave_rx_valid) rxv_c[3]++;
        if (if0.slave_underrun) und_c[0]++;
        if (if1.slave_underrun) und_c[1]++;
        if (if2.slave_underrun) und_c[2]++;
        if (if3.slave_underrun) und_c[3]++;
        if (if0.slave_frame_err) err_c[0]++;
        if (if1.slave_frame_err) err_c[1]++;
        if (if2.slave_frame_err) err_c[2]++;
        if (if3.slave_frame_err) err_c[3]++;
        if (if0.slave_tx_ack && q0.size() != 0) void'(q0.pop_front());
        if (if1.slave_tx_ack && q1.size() != 0) void'(q1.pop_front());
        if (if2.slave_tx_ack && q2.size() != 0) void'(q2.pop_front());
        if (if3.slave_tx_ack && q3.size() != 0) void'(q3.pop_front());
        if0.slave_tx_valid = (q0.size() != 0);
        if1.slave_tx_valid = (q1.size() != 0);
        if2.slave_tx_valid = (q2.size() != 0);
        if3.slave_tx_valid = (q3.size() != 0);
        if0.slave_tx_data  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        if1.slave_tx_data  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        if2.slave_tx_data  = (q2.size() != 0) ? q2[0]      : 16'h0000;
        if3.slave_tx_data  = (q3.size() != 0) ? q3[0][7:0] : 8'h00;
    end

    task automatic frame_begin(input int k, input bit cpol);
        sel   = k;
        sck   = cpol;
        #(2 * H);
        ss_n[k] = 1'b0;
        #(2 * H);
    endtask

    task automatic frame_end(input int k);
        #H;
        ss_n[k] = 1'b1;
        #(2 * H);
    endtask

    // Master side of one word (or the first n bits of it) of width w.
    task automatic xfer(input bit cpol, input bit cpha, input int w, input int n, input bit msbf,
                        input logic [15:0] tx, output logic [15:0] rx);
        int b;
        rx = '0;
        if (!cpha) mosi = tx[msbf ? w - 1 : 0];
        #H;
        for (int i = 0; i < n; i++) begin
            b = msbf ? w - 1 - i : i;
            if (!cpha) begin
                rx[b] = miso_m;
                sck   = !cpol;
                #H;
                sck   = cpol;
                if (i + 1 < w) mosi = tx[msbf ? w - 2 - i : i + 1];
                #H;
            end else begin
                sck  = !cpol;
                mosi = tx[b];
                #H;
                rx[b] = miso_m;
                sck   = cpol;
                #H;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (miso0 !== 1'b0) begin failures++; $display("FAIL rst_miso got=%b exp=0", miso0); end
        checks++; if (oe0 !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", oe0); end
        checks++; if (if0.slave_rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", if0.slave_rx_data); end
        checks++; if (if0.slave_tx_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", if0.slave_tx_ack); end
        checks++; if (if0.slave_rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rxv got=%b exp=0", if0.slave_rx_valid); end
        checks++; if (if0.slave_underrun !== 1'b0) begin failures++; $display("FAIL rst_und got=%b exp=0", if0.slave_underrun); end
        checks++; if (if0.slave_frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got=%b exp=0", if0.slave_frame_err); end
        checks++; if (oe3 !== 1'b0) begin failures++; $display("FAIL rst_oe3 got=%b exp=0", oe3); end
    endtask

    task automatic test_mode0_byte();
        logic [15:0] r;
        int a0, v0, u0c, e0;
        a0 = ack_c[0]; v0 = rxv_c[0]; u0c = und_c[0]; e0 = err_c[0];
        q0.push_back(16'h00A5);
        frame_begin(0, 1'b0);
        xfer(1'b0, 1'b0, 8, 8, 1'b1, 16'h003C, r);
        frame_end(0);
        checks++; if (r !== 16'h00A5) begin failures++; $display("FAIL m0_miso_word got=%h exp=00a5", r); end
        checks++; if (if0.slave_rx_data !== 8'h3C) begin failures++; $display("FAIL m0_rx_data got=%h exp=3c", if0.slave_rx_data); end
        checks++; if (ack_c[0] - a0 != 1) begin failures++; $display("FAIL m0_acks got=%0d exp=1", ack_c[0] - a0); end
        checks++; if (rxv_c[0] - v0 != 1) begin failures++; $display("FAIL m0_rxv got=%0d exp=1", rxv_c[0] - v0); end
        // Nothing queued at the word-end reload, so the reload itself underruns once.
        checks++; if (und_c[0] - u0c != 1) begin failures++; $display("FAIL m0_und got=%0d exp=1", und_c[0] - u0c); end
        checks++; if (err_c[0] - e0 != 0) begin failures++; $display("FAIL m0_ferr got=%0d exp=0", err_c[0] - e0); end
        checks++; if (oe0 !== 1'b0 || miso0 !== 1'b0) begin failures++; $display("FAIL m0_idle_pins got=%b%b exp=00", oe0, miso0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r1, r2;
        int a, v, u, e;
        a = ack_c[3]; v = rxv_c[3]; u = und_c[3]; e = err_c[3];
        q3.push_back(16'h0081);
        q3.push_back(16'h007E);
        frame_begin(3, 1'b1);
        xfer(1'b1, 1'b1, 8, 8, 1'b1, 16'h00C3, r1);
        checks++; if (if3.slave_rx_data !== 8'hC3) begin failures++; $display("FAIL b2b_rx0 got=%h exp=c3", if3.slave_rx_data); end
        xfer(1'b1, 1'b1, 8, 8, 1'b1, 16'h0018, r2);
        frame_end(3);
        checks++; if (if3.slave_rx_data !== 8'h18) begin failures++; $display("FAIL b2b_rx1 got=%h exp=18", if3.slave_rx_data); end
        checks++; if (r1 !== 16'h0081) begin failures++; $display("FAIL b2b_miso0 got=%h exp=0081", r1); end
        checks++; if (r2 !== 16'h007E) begin failures++; $display("FAIL b2b_miso1 got=%h exp=007e", r2); end
        checks++; if (ack_c[3] - a != 2) begin failures++; $display("FAIL b2b_acks got=%0d exp=2", ack_c[3] - a); end
        checks++; if (rxv_c[3] - v != 2) begin failures++; $display("FAIL b2b_rxv got=%0d exp=2", rxv_c[3] - v); end
        checks++; if (und_c[3] - u != 1) begin failures++; $display("FAIL b2b_und got=%0d exp=1", und_c[3] - u); end
        checks++; if (err_c[3] - e != 0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", err_c[3] - e); end
    endtask

    task automatic test_underrun();
        logic [15:0] r;
        int a, v, u;
        a = ack_c[1]; v = rxv_c[1]; u = und_c[1];
        frame_begin(1, 1'b0);
        checks++; if (und_c[1] - u != 1) begin failures++; $display("FAIL ur_load_und got=%0d exp=1", und_c[1] - u); end
        checks++; if (oe1 !== 1'b1) begin failures++; $display("FAIL ur_oe got=%b exp=1", oe1); end
        xfer(1'b0, 1'b1, 8, 8, 1'b1, 16'h0096, r);
        frame_end(1);
        checks++; if (r !== 16'h00FF) begin failures++; $display("FAIL ur_miso_word got=%h exp=00ff", r); end
        checks++; if (if1.slave_rx_data !== 8'h96) begin failures++; $display("FAIL ur_rx_data got=%h exp=96", if1.slave_rx_data); end
        checks++; if (rxv_c[1] - v != 1) begin failures++; $display("FAIL ur_rxv got=%0d exp=1", rxv_c[1] - v); end
        checks++; if (ack_c[1] - a != 0) begin failures++; $display("FAIL ur_acks got=%0d exp=0", ack_c[1] - a); end
        checks++; if (und_c[1] - u != 2) begin failures++; $display("FAIL ur_total_und got=%0d exp=2", und_c[1] - u); end
    endtask

    task automatic test_abort();
        logic [15:0] r;
        int v, e;
        v = rxv_c[0]; e = err_c[0];
        frame_begin(0, 1'b0);
        xfer(1'b0, 1'b0, 8, 3, 1'b1, 16'h00F0, r);
        checks++; if (oe0 !== 1'b1) begin failures++; $display("FAIL ab_oe_active got=%b exp=1", oe0); end
        ss_n[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (oe0 !== 1'b0) begin failures++; $display("FAIL ab_oe_3clk got=%b exp=0", oe0); end
        #(2 * H);
        checks++; if (err_c[0] - e != 1) begin failures++; $display("FAIL ab_ferr got=%0d exp=1", err_c[0] - e); end
        checks++; if (rxv_c[0] - v != 0) begin failures++; $display("FAIL ab_rxv got=%0d exp=0", rxv_c[0] - v); end
        checks++; if (if0.slave_rx_data !== 8'h3C) begin failures++; $display("FAIL ab_rx_kept got=%h exp=3c", if0.slave_rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] r;
        int e, v;
        frame_begin(0, 1'b0);
        xfer(1'b0, 1'b0, 8, 4, 1'b1, 16'h00FF, r);
        e = err_c[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({miso0, oe0, if0.slave_tx_ack, if0.slave_rx_valid, if0.slave_underrun, if0.slave_frame_err} !== 6'b0)
            begin failures++; $display("FAIL mr_outs got=%b exp=000000", {miso0, oe0, if0.slave_tx_ack, if0.slave_rx_valid, if0.slave_underrun, if0.slave_frame_err}); end
        checks++; if (if0.slave_rx_data !== 8'h00) begin failures++; $display("FAIL mr_rx_data got=%h exp=00", if0.slave_rx_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ss_n[0] = 1'b1;
        #(2 * H);
        checks++; if (err_c[0] - e != 0) begin failures++; $display("FAIL mr_ferr got=%0d exp=0", err_c[0] - e); end
        v = rxv_c[0];
        q0.push_back(16'h00C7);
        frame_begin(0, 1'b0);
        xfer(1'b0, 1'b0, 8, 8, 1'b1, 16'h005A, r);
        frame_end(0);
        checks++; if (if0.slave_rx_data !== 8'h5A) begin failures++; $display("FAIL mr_rx_data2 got=%h exp=5a", if0.slave_rx_data); end
        checks++; if (r !== 16'h00C7) begin failures++; $display("FAIL mr_miso_word got=%h exp=00c7", r); end
        checks++; if (rxv_c[0] - v != 1) begin failures++; $display("FAIL mr_rxv got=%0d exp=1", rxv_c[0] - v); end
        checks++; if (err_c[0] - e != 0) begin failures++; $display("FAIL mr_ferr2 got=%0d exp=0", err_c[0] - e); end
    endtask

    task automatic test_wide_lsb();
        logic [15:0] r;
        int a, v;
        a = ack_c[2]; v = rxv_c[2];
        q2.push_back(16'hBEEF);
        frame_begin(2, 1'b1);
        xfer(1'b1, 1'b0, 16, 16, 1'b0, 16'h1234, r);
        frame_end(2);
        checks++; if (if2.slave_rx_data !== 16'h1234) begin failures++; $display("FAIL w16_rx_data got=%h exp=1234", if2.slave_rx_data); end
        checks++; if (r !== 16'hBEEF) begin failures++; $display("FAIL w16_miso_word got=%h exp=beef", r); end
        checks++; if (ack_c[2] - a != 1) begin failures++; $display("FAIL w16_acks got=%0d exp=1", ack_c[2] - a); end
        checks++; if (rxv_c[2] - v != 1) begin failures++; $display("FAIL w16_rxv got=%0d exp=1", rxv_c[2] - v); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ack_c[i] = 0; rxv_c[i] = 0; und_c[i] = 0; err_c[i] = 0;
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_mode0_byte();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid_frame();
        test_wide_lsb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
Parametrised, system-clocked successor to the SPI slave.
- Samples SCK, SS and MOSI with the local clock through synchronisers, so no logic runs on SCK.
- Supports all four CPOL/CPHA modes, configurable word width and bit order.
- Supports back-to-back multi-word frames under one SS assertion, with a TX load handshake, RX valid strobe, underrun and frame-abort reporting.
- Sits between the external SPI pins and the register or stream logic in the slave FPGA.

Parameters:
DATA_W, 8, word width in bits (≥2)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
DEFAULT_TX, all-ones, word sent when no TX data is available (underrun)

Ports:
slave_clk  in  1  system clock; must be ≥ 8× SCK frequency
slave_reset  in  1  synchronous, active-high reset
slave_sck  in  1  SPI clock from master (asynchronous)
slave_ss  in  1  slave select, active low (asynchronous)
slave_mosi  in  1  serial data from master (asynchronous)
slave_miso  out  1  serial data to master
slave_miso_oe  out  1  MISO output enable (high while selected)
slave_tx_data  in  DATA_W  next word to transmit
slave_tx_valid  in  1  slave_tx_data holds a word
slave_tx_ack  out  1  1-cycle pulse: slave_tx_data latched into the shifter
slave_rx_data  out  DATA_W  last complete received word
slave_rx_valid  out  1  1-cycle pulse: slave_rx_data updated
slave_underrun  out  1  1-cycle pulse: DEFAULT_TX loaded because slave_tx_valid was low
slave_frame_err  out  1  1-cycle pulse: SS released with a partial word

Behaviour:
- Reset (synchronous, slave_reset=1 at the slave_clk edge) has priority over everything.
  - All outputs are 0: miso, miso_oe, tx_ack, rx_data, rx_valid, underrun, frame_err.
  - The FSM goes to IDLE and the bit counter is 0.
  - Reset mid-frame abandons the frame silently; no frame_err is raised.
- Synchronisers: each of sck, ss and mosi passes through 2 flops, plus a third flop on sck and ss for edge detection.
  - Pin-to-event latency is 3 slave_clk cycles.
  - Leading edge = sck leaving CPOL; trailing edge = sck returning to CPOL.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: miso_oe=0. Synced ss falling → LOAD.
  - LOAD (1 cycle): load tx_shift.
    - If slave_tx_valid=1: load slave_tx_data and pulse tx_ack.
    - Otherwise: load DEFAULT_TX and pulse underrun.
    - bit_cnt←0, miso_oe←1, then → SHIFT.
  - SHIFT:
    - Sample event (leading if CPHA=0, trailing if CPHA=1): shift mosi into rx_shift at the end selected by MSB_FIRST; bit_cnt+1.
    - Shift event (the other edge): advance tx_shift so the next bit appears on miso.
    - CPHA=1 only: the first leading edge after LOAD is ignored as a shift, because bit 0 is already presented by LOAD.
    - On the sample event that completes bit DATA_W−1:
      - rx_data←assembled word and pulse rx_valid in the following cycle.
      - bit_cnt←0.
      - Reload tx_shift with the same tx_valid/DEFAULT_TX rule as LOAD, in the same cycle, so the next word's first bit is on miso before the next shift event.
      - Stay in SHIFT.
- miso: always the current output bit of tx_shift (MSB or LSB per MSB_FIRST); 0 in IDLE.
- SS release: synced ss rising in any state → IDLE, miso_oe←0.
  - If bit_cnt≠0, pulse frame_err; the partial word is discarded and rx_data is unchanged.
  - If bit_cnt=0, release is clean: no pulse. A word that was loaded but not started is dropped without error.
- Simultaneous events:
  - ss rising in the same cycle as a final sample event: the word completes (rx_valid pulses), then the block goes to IDLE with no frame_err.
  - ss rising with a shift event: the block goes to IDLE and the shift is ignored.
- bit_cnt width is $clog2(DATA_W); it wraps explicitly at DATA_W−1, not by overflow.
- SCK edges while in IDLE are ignored.

Decomposition:
- Package spi_pkg:
  - spi_state_e enum {IDLE, LOAD, SHIFT}
  - localparams SYNC_STAGES=2 and MIN_CLK_RATIO=8
  - function to decode CPOL/CPHA into leading/trailing event roles
- Sub-module spi_sync_edge: parametrised N-flop synchroniser with rise/fall pulse outputs; instanced for sck and ss, plus a plain synchroniser for mosi.

Test Plan:
1. Mode 0, DATA_W=8, MSB_FIRST=1, tx_data=0xA5 valid; master sends 0x3C in one byte frame → miso bits 1,0,1,0,0,1,0,1; one tx_ack; rx_valid once with rx_data=0x3C; no frame_err.
2. Mode 3, tx_valid held high with 0x81 then 0x7E; master sends 0xC3,0x18 in one SS frame → two tx_acks, rx_data 0xC3 then 0x18; master reads 0x81,0x7E.
3. Underrun: tx_valid=0 in mode 1 → master reads 0xFF; underrun pulses once at LOAD; rx still correct.
4. Abort: SS released after 3 sample edges → frame_err pulses once; no rx_valid; rx_data keeps its previous value; miso_oe=0 within 3 clk.
5. Reset mid-frame: assert slave_reset after 4 bits, then run a clean frame → all outputs 0 at reset; no frame_err; next frame receives 0x5A correctly.
6. DATA_W=16, MSB_FIRST=0, mode 2: master sends 0x1234 LSB-first → rx_data=0x1234; tx 0xBEEF appears LSB-first on miso.
